// File: rtl/timer_prescaler_mc.sv
// timer_prescaler_mc: NUM_CH independent compare timers with one-shot, auto-reload and cascade modes.
module timer_prescaler_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       reset_count_i,
  input  logic [NUM_CH-1:0]       enable_count_i,
  input  logic [NUM_CH-1:0]       oneshot_i,
  input  logic [NUM_CH-1:0]       cascade_i,
  input  logic [NUM_CH*CNT_W-1:0] compare_value_i,
  input  logic [NUM_CH-1:0]       write_counter_i,
  input  logic [NUM_CH*CNT_W-1:0] counter_value_i,
  output logic [NUM_CH*CNT_W-1:0] counter_value_o,
  output logic [NUM_CH-1:0]       target_reached_o,
  output logic [NUM_CH-1:0]       done_o,
  output logic                    irq_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  logic [NUM_CH-1:0] tr_v, done_v, prev_tr, tick;
  logic irq_q, irq_d;
  // Bit 0 sees a constant 1 so channel 0 ignores its cascade bit.
  assign prev_tr = (tr_v << 1) | NUM_CH'(1);
  assign tick = enable_count_i & (~cascade_i | prev_tr);
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cmp;
    logic tr_q, tr_d, done_q, done_d;
    assign cmp = compare_value_i[n*CNT_W +: CNT_W];
    always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      tr_d = 1'b0;
      done_d = done_q;
      if (reset_count_i[n]) begin
        cnt_d = '0;
        done_d = 1'b0;
        state_d = IDLE;
      end else if (write_counter_i[n]) begin
        cnt_d = counter_value_i[n*CNT_W +: CNT_W];
        done_d = 1'b0;
        state_d = IDLE;
      end else if (state_q != DONE) begin
        state_d = enable_count_i[n] ? RUN : IDLE;
        if (tick[n] && cnt_q == cmp) begin
          cnt_d = '0;
          tr_d = 1'b1;
          if (oneshot_i[n]) begin
            state_d = DONE;
            done_d = 1'b1;
          end
        end else if (tick[n]) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= IDLE;
        cnt_q <= '0;
        tr_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q <= cnt_d;
        tr_q <= tr_d;
        done_q <= done_d;
      end
    end
    assign tr_v[n] = tr_q;
    assign done_v[n] = done_q;
    assign counter_value_o[n*CNT_W +: CNT_W] = cnt_q;
  end
  always_comb irq_d = |tr_v;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_q <= 1'b0;
    else irq_q <= irq_d;
  end
  assign target_reached_o = tr_v;
  assign done_o = done_v;
  assign irq_o = irq_q;
endmodule
